vr_elastic_buffer: RTL and testbench

VR_ELASTIC_BUFFER -- requirements
Module: vr_elastic_buffer

---
 rtl/vr_elastic_buffer.sv | 115 +++++++++++
 tb/tb_vr_elastic_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vr_elastic_buffer.sv
// ---------------------------------------------------------------------------
// vr_elastic_buffer
//
// Valid/ready elastic buffer (circular FIFO) with registered handshake
// outputs. Both ready_up_out and valid_down_out come only from flops, so the
// block breaks every combinational path between upstream and downstream.
//
// Handshake semantics, identical on both sides: a beat transfers on a
// rising clk edge where valid and ready are both 1. A source holds valid
// and data stable until the transfer happens. A sink may raise or drop
// ready at any time. Data is ignored in any cycle without a transfer.
//
// Parameters
//   WIDTH  payload width in bits (>= 1)
//   DEPTH  number of storage entries (power of two, >= 2)
//
// Ports
//   clk             clock, rising-edge active
//   rst_n           asynchronous active-low reset
//   data_in         upstream payload
//   valid_up_in     upstream valid
//   ready_up_out    ready to upstream (count < DEPTH, and out of reset)
//   data_out        oldest stored entry, zero when empty
//   valid_down_out  valid to downstream (count > 0)
//   ready_down_in   downstream ready
//   count           current occupancy
//   stall_cnt       cycles with valid_down_out=1 and ready_down_in=0,
//                   saturating at 16'hFFFF
//
// Optional feature: define VR_ELASTIC_STALL_CNT_EN to add the stall_cnt
// port and its counter. Without the macro the port and logic are absent.
// ---------------------------------------------------------------------------
module vr_elastic_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       valid_up_in,
  output logic                       ready_up_out,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_down_out,
  input  logic                       ready_down_in,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef VR_ELASTIC_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  // Holds ready_up_out low while in reset and until the first edge after
  // rst_n deasserts, so nothing is accepted during the reset window.
  logic             out_of_reset;
  logic             push;
  logic             pop;

  // Handshake outputs depend only on registered state.
  assign ready_up_out   = out_of_reset && (count < FULL_COUNT);
  assign valid_down_out = (count != '0);
  assign data_out       = valid_down_out ? mem[rd_ptr] : '0;

  // A push while full is refused even if a pop happens in the same cycle;
  // ready_up_out is not recomputed from ready_down_in.
  assign push = valid_up_in && ready_up_out;
  assign pop  = valid_down_out && ready_down_in;

  // Storage array is not reset; entries are only read when count says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      // Pointers are exactly AW bits wide, so DEPTH-1 wraps to 0 naturally.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

`ifdef VR_ELASTIC_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (valid_down_out && !ready_down_in && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vr_elastic_buffer.sv
// ---------------------------------------------------------------------------
// tb_vr_elastic_buffer
//
// Bench for vr_elastic_buffer with WIDTH=8, DEPTH=4. A queue-based model
// (exp_q) tracks which beats the buffer must hold; a compare process checks
// every DUT output against it on each falling edge. Directed sequences pin
// the model with literal values, then a randomized phase stresses it.
// Inputs change 2 time units after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vr_elastic_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_up_in = 1'b0;
  logic             ready_up_out;
  logic [WIDTH-1:0] data_out;
  logic             valid_down_out;
  logic             ready_down_in = 1'b0;
  logic [2:0]       count;
`ifdef VR_ELASTIC_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  logic [WIDTH-1:0] exp_q[$];
  logic             m_alive = 1'b0;
  logic [15:0]      m_stall = '0;
  // Beats the DUT handed downstream, as seen on its outputs
  logic [WIDTH-1:0] pop_log[$];

  vr_elastic_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .valid_up_in    (valid_up_in),
    .ready_up_out   (ready_up_out),
    .data_out       (data_out),
    .valid_down_out (valid_down_out),
    .ready_down_in  (ready_down_in),
    .count          (count)
`ifdef VR_ELASTIC_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Occupancy is the queue length; a beat goes in when valid is high and
  // there is room (and the block is out of reset), the head leaves when
  // there is a head and downstream is ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_alive <= 1'b0;
      m_stall <= '0;
    end else begin
      if (exp_q.size() > 0 && !ready_down_in && m_stall != 16'hFFFF)
        m_stall <= m_stall + 16'd1;
      if (exp_q.size() > 0 && ready_down_in) begin
        if (valid_up_in && m_alive && exp_q.size() < DEPTH) exp_q.push_back(data_in);
        void'(exp_q.pop_front());
      end else if (valid_up_in && m_alive && exp_q.size() < DEPTH) begin
        exp_q.push_back(data_in);
      end
      m_alive <= 1'b1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("ready_up_out", 32'(ready_up_out), 32'(m_alive && exp_q.size() < DEPTH));
    check("valid_down_out", 32'(valid_down_out), 32'(exp_q.size() > 0));
    check("data_out", 32'(data_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
    check("count", 32'(count), 32'(exp_q.size()));
    check("count_bound", 32'(count <= 3'd4), 32'd1);
`ifdef VR_ELASTIC_STALL_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    if (valid_down_out && ready_down_in) pop_log.push_back(data_out);
  end

  // ---------------- driver tasks ----------------
  // Apply inputs for one cycle; returns 2 time units after that edge.
  task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r);
    valid_up_in   = v;
    data_in       = d;
    ready_down_in = r;
    @(posedge clk);
    #2;
  endtask

  task automatic check_log(input string name, input logic [WIDTH-1:0] exp_vals[$]);
    check({name, "_len"}, 32'(pop_log.size()), 32'(exp_vals.size()));
    for (int i = 0; i < exp_vals.size() && i < pop_log.size(); i++)
      check(name, 32'(pop_log[i]), 32'(exp_vals[i]));
    pop_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] exp_vals[$];
    int pv;
    int pr;

    // Reset state
    #1;
    check("rst_ready", 32'(ready_up_out), 32'd0);
    check("rst_valid", 32'(valid_down_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    check("rel_ready_before_edge", 32'(ready_up_out), 32'd0);
    cycle(1'b0, 8'hEE, 1'b1);
    check("rel_ready_after_edge", 32'(ready_up_out), 32'd1);

    // Single beat into an empty buffer: visible one edge later, then gone
    pop_log.delete();
    cycle(1'b1, 8'h11, 1'b1);
    check("one_valid", 32'(valid_down_out), 32'd1);
    check("one_data", 32'(data_out), 32'h11);
    check("one_count", 32'(count), 32'd1);
    cycle(1'b0, 8'hAA, 1'b1);
    check("one_count_after", 32'(count), 32'd0);
    check("one_data_after", 32'(data_out), 32'd0);
    exp_vals = '{8'h11};
    check_log("one_log", exp_vals);

    // Fill to full, fifth beat held until one cycle after the first pop
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(ready_up_out), 32'd0);
    cycle(1'b1, 8'h05, 1'b0);
    check("full_hold_count", 32'(count), 32'd4);
    cycle(1'b1, 8'h05, 1'b1);          // pop of 0x01, push refused
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_ready", 32'(ready_up_out), 32'd1);
    check("full_pop_head", 32'(data_out), 32'h02);
    cycle(1'b1, 8'h05, 1'b0);          // now 0x05 is accepted
    check("full_push5_count", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h77, 1'b1);
    check("full_drained", 32'(count), 32'd0);
    exp_vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_log("full_log", exp_vals);

    // Streaming at full throughput: occupancy stays at one
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b1);
      check("stream_count", 32'(count), 32'd1);
      check("stream_data", 32'(data_out), 32'(i));
    end
    cycle(1'b0, 8'h00, 1'b1);
    check("stream_drained", 32'(count), 32'd0);
    exp_vals.delete();
    for (int i = 0; i < 16; i++) exp_vals.push_back(8'(i));
    check_log("stream_log", exp_vals);

    // Reset mid-stream with three beats stored
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
    check("mid_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_down_out), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_ready", 32'(ready_up_out), 32'd0);
    #1;
    cycle(1'b1, 8'hBB, 1'b1);          // push attempt during reset is refused
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    check("mid_rel_ready", 32'(ready_up_out), 32'd1);
    check("mid_rel_valid", 32'(valid_down_out), 32'd0);
    check("mid_rel_count", 32'(count), 32'd0);
    pop_log.delete();
    cycle(1'b1, 8'h5A, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    exp_vals = '{8'h5A};
    check_log("mid_log", exp_vals);

    // Randomized traffic with varying bias per block
    for (int blk = 0; blk < 10; blk++) begin
      pv = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 1000; i++)
        cycle(($urandom_range(0, 99) < pv), 8'($urandom), ($urandom_range(0, 99) < pr));
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'($urandom), 1'b1);
    check("rand_drained", 32'(count), 32'd0);

`ifdef VR_ELASTIC_STALL_CNT_EN
    // One beat held against a stalled sink until the counter saturates
    rst_n = 1'b0;
    #1;
    check("stall_rst", 32'(stall_cnt), 32'd0);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    for (int i = 0; i < 70000; i++) cycle(1'b0, 8'h00, 1'b0);
    check("stall_sat", 32'(stall_cnt), 32'hFFFF);
    cycle(1'b0, 8'h00, 1'b1);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
